// File: rtl/uart_rx_packer.sv
// UART receiver with configurable frame format that packs N_WORDS received words
// into one wide beat on a valid/ready output, flagging framing, parity and overflow errors.
module uart_rx_packer #(
    parameter int CLOCKS_PER_PULSE = 434,
    parameter int BITS_PER_WORD    = 8,
    parameter int N_WORDS          = 4,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               rx,
    output logic [N_WORDS*BITS_PER_WORD-1:0]   m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               frame_err,
    output logic                               parity_err,
    output logic                               overflow
);

    localparam int CW   = $clog2(CLOCKS_PER_PULSE);
    localparam int IW   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int BCW  = $clog2(BITS_PER_WORD + 1);
    localparam int PW   = N_WORDS * BITS_PER_WORD;
    localparam int HALF = CLOCKS_PER_PULSE / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                   state_q, state_d;
    logic                     sync1_q, sync2_q;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [BCW-1:0]           bit_q, bit_d;
    logic [BITS_PER_WORD-1:0] word_q, word_d;
    logic                     par_err_q, par_err_d;
    logic                     stop_bad_q, stop_bad_d;
    logic [IW-1:0]            widx_q, widx_d;
    logic [PW-1:0]            pack_q, pack_d;
    logic [PW-1:0]            m_data_q, m_data_d;
    logic                     m_valid_q, m_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic                     parity_err_q, parity_err_d;
    logic                     overflow_q, overflow_d;

    logic                     rxs;
    logic                     tick;
    logic                     exp_par;
    logic                     stop_bad_now;
    logic                     complete;
    logic [PW-1:0]            pack_ins;

    assign rxs        = sync2_q;
    assign tick       = (cnt_q == CW'(CLOCKS_PER_PULSE - 1));
    assign exp_par    = (PARITY == 1) ? ^word_q : ~^word_q;
    assign stop_bad_now = stop_bad_q | ~rxs;

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

    // Pack register with the just-received word dropped into its slot.
    always_comb begin
        pack_ins = pack_q;
        for (int i = 0; i < N_WORDS; i++) begin
            if (widx_q == IW'(i)) begin
                pack_ins[i*BITS_PER_WORD +: BITS_PER_WORD] = word_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        word_d       = word_q;
        par_err_d    = par_err_q;
        stop_bad_d   = stop_bad_q;
        widx_d       = widx_q;
        pack_d       = pack_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overflow_d   = 1'b0;
        complete     = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        bit_d      = '0;
                        par_err_d  = 1'b0;
                        stop_bad_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d  = '0;
                    word_d = {rxs, word_q[BITS_PER_WORD-1:1]};
                    if (bit_q == BCW'(BITS_PER_WORD - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BCW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                    if (rxs != exp_par) begin
                        par_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (bit_q == BCW'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        // Framing error outranks a pending parity error.
                        if (stop_bad_now) begin
                            frame_err_d = 1'b1;
                            widx_d      = '0;
                            state_d     = S_WAIT_IDLE;
                        end else if (par_err_q) begin
                            parity_err_d = 1'b1;
                            widx_d       = '0;
                            state_d      = S_IDLE;
                        end else begin
                            pack_d  = pack_ins;
                            state_d = S_IDLE;
                            if (widx_q == IW'(N_WORDS - 1)) begin
                                complete = 1'b1;
                                widx_d   = '0;
                            end else begin
                                widx_d = widx_q + IW'(1);
                            end
                        end
                    end else begin
                        bit_d      = bit_q + BCW'(1);
                        stop_bad_d = stop_bad_now;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new packet may replace one that is being accepted this same cycle.
        if (complete) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = pack_ins;
                m_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            word_q       <= '0;
            par_err_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            widx_q       <= '0;
            pack_q       <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            word_q       <= word_d;
            par_err_q    <= par_err_d;
            stop_bad_q   <= stop_bad_d;
            widx_q       <= widx_d;
            pack_q       <= pack_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Bench for uart_rx_packer: an 8N1 x4 instance and an 8O2 x3 instance driven with
// directed and random frames, checked against a word/packet-level model.
module tb_uart_rx_packer;

    localparam int CPP = 16;
    localparam int B   = 8;
    localparam int N_A = 4;
    localparam int N_P = 3;

    logic clk;
    logic rstn;
    logic rx_a, rx_p;
    logic ready_a, ready_p;
    logic [N_A*B-1:0] data_a;
    logic [N_P*B-1:0] data_p;
    logic valid_a, valid_p;
    logic ferr_a, perr_a, ovf_a;
    logic ferr_p, perr_p, ovf_p;

    uart_rx_packer #(
        .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(B), .N_WORDS(N_A), .PARITY(0), .STOP_BITS(1)
    ) u_dut_a (
        .clk(clk), .rstn(rstn), .rx(rx_a), .m_data(data_a), .m_valid(valid_a),
        .m_ready(ready_a), .frame_err(ferr_a), .parity_err(perr_a), .overflow(ovf_a)
    );

    uart_rx_packer #(
        .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(B), .N_WORDS(N_P), .PARITY(2), .STOP_BITS(2)
    ) u_dut_p (
        .clk(clk), .rstn(rstn), .rx(rx_p), .m_data(data_p), .m_valid(valid_p),
        .m_ready(ready_p), .frame_err(ferr_p), .parity_err(perr_p), .overflow(ovf_p)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference model: words collected per instance, expected packets, expected error counts
    int          words_a[$];
    int          words_p[$];
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_p_q[$];
    int          pend[2];
    int          x_ferr[2], x_perr[2], x_ovf[2];
    int          hi_ferr[2], hi_perr[2], hi_ovf[2];

    task automatic model_frame(input int inst, input int word, input bit pbad, input bit sbad);
        int          n;
        logic [63:0] pkt;
        bit          rdy;
        n   = (inst == 0) ? N_A : N_P;
        rdy = (inst == 0) ? ready_a : ready_p;
        if (sbad) begin
            x_ferr[inst]++;
            if (inst == 0) words_a.delete(); else words_p.delete();
        end else if (pbad && inst == 1) begin
            x_perr[inst]++;
            words_p.delete();
        end else begin
            if (inst == 0) words_a.push_back(word); else words_p.push_back(word);
            if (((inst == 0) ? words_a.size() : words_p.size()) == n) begin
                pkt = '0;
                for (int i = 0; i < n; i++) begin
                    pkt = pkt + (64'((inst == 0) ? words_a[i] : words_p[i]) << (i * B));
                end
                if (pend[inst] != 0) begin
                    x_ovf[inst]++;
                end else begin
                    if (inst == 0) exp_a_q.push_back(pkt); else exp_p_q.push_back(pkt);
                    pend[inst] = rdy ? 0 : 1;
                end
                if (inst == 0) words_a.delete(); else words_p.delete();
            end
        end
    endtask

    // driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int inst, input logic v);
        if (inst == 0) rx_a = v; else rx_p = v;
    endtask

    task automatic drive_bit(input int inst, input logic v);
        set_rx(inst, v);
        wait_clks(CPP);
    endtask

    task automatic set_ready(input int inst, input logic v);
        if (inst == 0) ready_a = v; else ready_p = v;
        if (v && pend[inst] != 0) pend[inst] = 0;
        wait_clks(2);
    endtask

    task automatic send_frame(input int inst, input int word, input bit pbad, input bit sbad,
                              input int extra_low, input int gap);
        logic [B-1:0] w;
        int           stops;
        w     = B'(word);
        stops = (inst == 0) ? 1 : 2;
        model_frame(inst, word, pbad, sbad);
        drive_bit(inst, 1'b0);
        for (int i = 0; i < B; i++) drive_bit(inst, w[i]);
        if (inst == 1) drive_bit(inst, (~^w) ^ pbad);
        for (int s = 0; s < stops; s++) drive_bit(inst, (sbad && s == 0) ? 1'b0 : 1'b1);
        for (int k = 0; k < extra_low; k++) drive_bit(inst, 1'b0);
        set_rx(inst, 1'b1);
        wait_clks(gap);
    endtask

    // scoreboard monitor
    logic [N_A*B-1:0] prev_data_a;
    logic [N_P*B-1:0] prev_data_p;
    logic             prev_hold_a, prev_hold_p;
    logic [63:0]      exp_v;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_hold_a = 1'b0;
            prev_hold_p = 1'b0;
        end else begin
            if (valid_a && ready_a) begin
                if (exp_a_q.size() == 0) check("a_spurious_xfer", 64'(data_a), 64'hdead);
                else begin
                    exp_v = exp_a_q.pop_front();
                    check("a_xfer_data", 64'(data_a), exp_v);
                end
            end
            if (valid_p && ready_p) begin
                if (exp_p_q.size() == 0) check("p_spurious_xfer", 64'(data_p), 64'hdead);
                else begin
                    exp_v = exp_p_q.pop_front();
                    check("p_xfer_data", 64'(data_p), exp_v);
                end
            end
            if (prev_hold_a) check("a_hold_stable", {valid_a, data_a}, {1'b1, prev_data_a});
            if (prev_hold_p) check("p_hold_stable", {valid_p, data_p}, {1'b1, prev_data_p});
            prev_hold_a = valid_a && !ready_a;
            prev_hold_p = valid_p && !ready_p;
            prev_data_a = data_a;
            prev_data_p = data_p;
            if (ferr_a) hi_ferr[0]++;
            if (perr_a) hi_perr[0]++;
            if (ovf_a)  hi_ovf[0]++;
            if (ferr_p) hi_ferr[1]++;
            if (perr_p) hi_perr[1]++;
            if (ovf_p)  hi_ovf[1]++;
            if (ferr_p && perr_p) check("p_err_exclusive", 1, 0);
        end
    end

    int r_inst, r_word;
    bit r_pbad, r_sbad;

    initial begin
        rstn = 1'b0; rx_a = 1'b1; rx_p = 1'b1; ready_a = 1'b1; ready_p = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; x_ferr[i] = 0; x_perr[i] = 0; x_ovf[i] = 0;
            hi_ferr[i] = 0; hi_perr[i] = 0; hi_ovf[i] = 0;
        end
        wait_clks(5);
        check("rst_a_valid", valid_a, 0);
        check("rst_a_data", 64'(data_a), 0);
        check("rst_a_errs", {ferr_a, perr_a, ovf_a}, 0);
        check("rst_p_valid", valid_p, 0);
        check("rst_p_data", 64'(data_p), 0);
        check("rst_p_errs", {ferr_p, perr_p, ovf_p}, 0);
        rstn = 1'b1;
        wait_clks(5);

        // basic packet on both instances
        send_frame(0, 'h12, 0, 0, 0, $urandom_range(1, 20));
        send_frame(0, 'h34, 0, 0, 0, $urandom_range(1, 20));
        send_frame(0, 'h56, 0, 0, 0, $urandom_range(1, 20));
        send_frame(0, 'h78, 0, 0, 0, $urandom_range(1, 20));
        check("a_basic_data", 64'(data_a), 64'h78563412);
        check("a_basic_valid_low", valid_a, 0);
        for (int i = 0; i < N_P; i++) send_frame(1, $urandom_range(0, 255), 0, 0, 0, $urandom_range(1, 20));

        // backpressure and overflow
        set_ready(0, 1'b0);
        send_frame(0, 'h04, 0, 0, 0, 3);
        send_frame(0, 'h03, 0, 0, 0, 3);
        send_frame(0, 'h02, 0, 0, 0, 3);
        send_frame(0, 'h01, 0, 0, 0, 3);
        check("a_bp_valid", valid_a, 1);
        check("a_bp_data1", 64'(data_a), 64'h01020304);
        send_frame(0, 'hDD, 0, 0, 0, 3);
        send_frame(0, 'hCC, 0, 0, 0, 3);
        send_frame(0, 'hBB, 0, 0, 0, 3);
        send_frame(0, 'hAA, 0, 0, 0, 3);
        check("a_bp_data_kept", 64'(data_a), 64'h01020304);
        check("a_bp_ovf_count", hi_ovf[0], 1);
        set_ready(0, 1'b1);
        check("a_bp_drained", valid_a, 0);

        // framing error discards partial packet
        send_frame(0, 'h11, 0, 0, 0, 5);
        send_frame(0, 'h22, 0, 0, 0, 5);
        send_frame(0, 'h55, 0, 1, 3, 5);
        check("a_ferr_pulse", hi_ferr[0], 1);
        send_frame(0, 'hC1, 0, 0, 0, 7);
        send_frame(0, 'hC2, 0, 0, 0, 7);
        send_frame(0, 'hC3, 0, 0, 0, 7);
        send_frame(0, 'hC4, 0, 0, 0, 7);
        check("a_after_ferr_data", 64'(data_a), 64'hC4C3C2C1);

        // odd parity: bad parity, both errors, then a clean packet
        send_frame(1, 'h3C, 0, 0, 0, 5);
        send_frame(1, 'hA5, 1, 0, 0, 5);
        check("p_perr_pulse", hi_perr[1], 1);
        send_frame(1, 'hA5, 1, 1, 0, 5);
        check("p_ferr_priority", {hi_ferr[1][7:0], hi_perr[1][7:0]}, 16'h0101);
        send_frame(1, 'hA5, 0, 0, 0, 5);
        send_frame(1, 'h5A, 0, 0, 0, 5);
        send_frame(1, 'h00, 0, 0, 0, 5);
        check("p_after_perr_data", 64'(data_p), 64'h005AA5);

        // glitch shorter than half a bit
        rx_a = 1'b0;
        wait_clks(CPP / 4);
        rx_a = 1'b1;
        wait_clks(2 * CPP);
        check("a_glitch_noerr", {hi_ferr[0][7:0], valid_a}, {8'd1, 1'b0});
        for (int i = 0; i < N_A; i++) send_frame(0, $urandom_range(0, 255), 0, 0, 0, $urandom_range(1, 20));

        // reset during bit 4 of word 2
        send_frame(0, 'h9A, 0, 0, 0, 4);
        send_frame(0, 'hBC, 0, 0, 0, 4);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        rx_a = 1'b0;
        wait_clks(CPP / 2);
        rstn = 1'b0;
        words_a.delete(); words_p.delete();
        pend[0] = 0; pend[1] = 0;
        wait_clks(1);
        check("rst_mid_a_valid", valid_a, 0);
        check("rst_mid_a_data", 64'(data_a), 0);
        check("rst_mid_p_data", 64'(data_p), 0);
        rx_a = 1'b1;
        wait_clks(3);
        rstn = 1'b1;
        wait_clks(CPP);
        send_frame(0, 'hF0, 0, 0, 0, 4);
        send_frame(0, 'h0F, 0, 0, 0, 4);
        send_frame(0, 'hE1, 0, 0, 0, 4);
        send_frame(0, 'h1E, 0, 0, 0, 4);
        check("rst_mid_after_data", 64'(data_a), 64'h1EE10FF0);

        // random mix with random backpressure and errors
        for (int k = 0; k < 36; k++) begin
            r_inst = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) set_ready(r_inst, $urandom_range(0, 1));
            r_word = $urandom_range(0, 255);
            r_pbad = (r_inst == 1) && ($urandom_range(0, 7) == 0);
            r_sbad = ($urandom_range(0, 11) == 0);
            send_frame(r_inst, r_word, r_pbad, r_sbad, 0, $urandom_range(1, 20));
        end
        set_ready(0, 1'b1);
        set_ready(1, 1'b1);
        wait_clks(20);

        for (int i = 0; i < 2; i++) begin
            check($sformatf("ferr_count_%0d", i), hi_ferr[i], x_ferr[i]);
            check($sformatf("perr_count_%0d", i), hi_perr[i], x_perr[i]);
            check($sformatf("ovf_count_%0d", i), hi_ovf[i], x_ovf[i]);
        end
        check("a_exp_drained", exp_a_q.size(), 0);
        check("p_exp_drained", exp_p_q.size(), 0);
        check("end_valid_low", {valid_a, valid_p}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
